uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Parametrised next-generation UART receiver. Configurable oversampling ratio, data length, parity mode (even/odd) and stop length.
- Adds a valid/ready output holding register, overrun detection, break detection, and per-frame framing/parity error flags.
- Sits between the input synchroniser and the UART register/FIFO layer. Driven by the shared baud tick generator.

Parameters:
- MAX_UART_DATA_W, 9, maximum data bits per frame; width of rx_data_o.
- MIN_UART_DATA_W, 5, data bits when data_len field is 0.
- OVERSAMPLE, 16, baud ticks per bit; must be even and >= 8.
- SAMPLE_COUNT_W, 4, width of the sample counter; equals clog2(OVERSAMPLE).
- DATA_COUNTER_W, 4, width of the data bit counter; equals clog2(MAX_UART_DATA_W).
- TOTAL_CONF_W, 5, width of rx_conf_i.

Ports:
- clk_i  in  1  top clock
- rst_i  in  1  asynchronous active-high reset
- baud_en_i  in  1  oversample tick, one clk wide
- rx_en_i  in  1  receiver enable
- uart_rx_i  in  1  synchronised serial input, idle high
- rx_conf_i  in  TOTAL_CONF_W  {data_len[2:0], stop2, parity_odd, parity_en}
  - Field order MSB->LSB is data_len[2:0], stop2, parity_odd, parity_en. With the default TOTAL_CONF_W=5 these are bits [4:3]/[2]/[1]/[0], so only data_len[1:0] is carried.
  - Widen TOTAL_CONF_W to 6 to carry data_len[2].
- rx_data_o  out  MAX_UART_DATA_W  received data, LSB-first assembled, upper bits zero
- rx_valid_o  out  1  holding register full
- rx_ready_i  in  1  consumer accepts data when valid&&ready
- rx_parity_err_o  out  1  parity error of the frame in the holding register
- rx_frame_err_o  out  1  stop bit sampled low, for the frame in the holding register
- rx_break_o  out  1  break: all data, parity and stop samples were 0
- rx_overrun_o  out  1  sticky; cleared by rx_ovr_clr_i
- rx_ovr_clr_i  in  1  one-cycle clear of rx_overrun_o
- rx_busy_o  out  1  FSM not in IDLE/OFF

Behaviour:
- Reset (async, rst_i=1): FSM=OFF. All counters 0. All outputs 0, including rx_data_o.
- All FSM and counter updates happen only on clk edges with baud_en_i=1. The output handshake and rx_ovr_clr_i act on every clk edge.
- States:
  - OFF -> IDLE when rx_en_i=1.
  - IDLE -> START when uart_rx_i=0. rx_conf_i is latched on this transition; it is ignored during a frame.
  - START: at sample MID=OVERSAMPLE/2-1, if the line is 1 (glitch) -> IDLE. Otherwise -> DATA at the final sample (OVERSAMPLE-1).
  - DATA: one bit per OVERSAMPLE ticks, sampled at MID. After bit N-1 (N = MIN_UART_DATA_W + data_len, saturated at MAX_UART_DATA_W) -> PARITY if parity_en, else STOP.
  - PARITY: sample at MID; -> STOP at the final sample.
  - STOP: 1 or 2 (stop2) bits. Frame completes at the MID sample of the last stop bit; FSM -> IDLE at that same tick, so a following start edge is accepted early.
- rx_en_i=0 in any state -> OFF at the next tick. A frame in progress is discarded, with no flags and no valid.
- Parity:
  - Expected parity bit = (^data) ^ parity_odd.
  - Mismatch sets parity_err for the frame.
  - Forced to 0 when parity_en=0.
- Completion, on the clk edge after the completing tick:
  - If rx_valid_o=0, or rx_valid_o&&rx_ready_i in the same cycle: load data and flags; rx_valid_o=1.
  - Otherwise: new frame dropped, holding register unchanged, rx_overrun_o<=1.
  - Overrun set and rx_ovr_clr_i in the same cycle: set wins.
- rx_valid_o&&rx_ready_i with no completion: rx_valid_o<=0. Data and flags hold their last values.
- Break:
  - rx_break_o=1 when every data bit, the parity bit (if enabled) and all stop samples were 0. rx_frame_err_o is also 1.
  - After a break, FSM waits in IDLE until uart_rx_i=1 before it will detect a new start (an internal line_high flag is required).
- rx_busy_o is combinational from state: 1 in START/DATA/PARITY/STOP.

Optional Feature:
- Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit value is the majority of samples at MID-1, MID and MID+1. The START glitch check uses the same vote, evaluated at MID+1. Stop completion moves to MID+1.
- Undefined: single sample at MID; no extra registers.

Decomposition:
- Package uart_pkg:
  - State encodings.
  - Conf field bit positions (PARITY_EN_B, PARITY_ODD_B, STOP2_B, DATA_LEN_LSB).
  - MID/LAST sample constants derived from OVERSAMPLE.
- One natural sub-module: uart_rx_holding_reg, owning the valid/ready register, flags and overrun logic. The FSM/sampler stays in uart_rx_core.

Test Plan:
- 8N1 (data_len=3, parity_en=0, stop2=0), OVERSAMPLE=16, baud_en_i=1 every clk, send 0xA5 -> after 1+8+0.5 bits (152 ticks) rx_valid_o=1, rx_data_o=0x0A5, all error flags 0.
- 7O2 (data_len=2, parity_odd=1, parity_en=1, stop2=1), send 0x35 with a wrong parity bit -> rx_data_o=0x035, rx_parity_err_o=1. A following correct frame 0x35 -> rx_parity_err_o=0.
- Two frames 0x11 then 0x22 with rx_ready_i=0 -> rx_data_o stays 0x011, rx_overrun_o=1. Pulse rx_ovr_clr_i -> 0. Then ready -> rx_valid_o=0.
- Line held low for 12 bit times in 8N1 -> one frame: rx_data_o=0, rx_break_o=1, rx_frame_err_o=1. No second start until the line returns high.
- Low pulse of 4 ticks on an idle line -> FSM returns to IDLE, rx_valid_o stays 0. Toggle rx_en_i=0 mid-DATA -> rx_busy_o=0 and no valid.
- Assert rst_i asynchronously mid-frame, between clk edges -> all outputs 0 immediately. Deassert and send 0x3C -> received correctly; repeat the whole test with UART_RX_MAJORITY_VOTE_EN defined and a one-tick glitch at MID -> data unaffected.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, conf field positions and sample-point helpers
package uart_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } rx_state_e;

  localparam int PARITY_EN_B  = 0;
  localparam int PARITY_ODD_B = 1;
  localparam int STOP2_B      = 2;
  localparam int DATA_LEN_LSB = 3;

  localparam int DEFAULT_OVERSAMPLE = 16;

  function automatic int mid_sample(input int oversample);
    return oversample / 2 - 1;
  endfunction

  function automatic int last_sample(input int oversample);
    return oversample - 1;
  endfunction

  localparam int DEFAULT_MID  = DEFAULT_OVERSAMPLE / 2 - 1;
  localparam int DEFAULT_LAST = DEFAULT_OVERSAMPLE - 1;

endpackage

// File: rtl/uart_rx_holding_reg.sv
// rtl/uart_rx_holding_reg.sv - valid/ready output register with per-frame flags and sticky overrun
module uart_rx_holding_reg #(
  parameter int DATA_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              parity_err_i,
  input  logic              frame_err_i,
  input  logic              break_i,
  input  logic              ready_i,
  input  logic              ovr_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              break_o,
  output logic              overrun_o
);

  logic accept;
  logic room;

  assign accept = valid_o & ready_i;
  // A frame may replace the held one only if the consumer takes the old one this cycle.
  assign room   = ~valid_o | ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (load_i && room) begin
        data_o       <= data_i;
        parity_err_o <= parity_err_i;
        frame_err_o  <= frame_err_i;
        break_o      <= break_i;
        valid_o      <= 1'b1;
      end else if (accept) begin
        valid_o <= 1'b0;
      end

      if (load_i && !room) begin
        overrun_o <= 1'b1;
      end else if (ovr_clr_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver FSM and bit sampler feeding the holding register.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 3-sample vote around MID.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int MAX_UART_DATA_W = 9,
  parameter int MIN_UART_DATA_W = 5,
  parameter int OVERSAMPLE      = 16,
  parameter int SAMPLE_COUNT_W  = 4,
  parameter int DATA_COUNTER_W  = 4,
  parameter int TOTAL_CONF_W    = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       baud_en_i,
  input  logic                       rx_en_i,
  input  logic                       uart_rx_i,
  input  logic [TOTAL_CONF_W-1:0]    rx_conf_i,
  output logic [MAX_UART_DATA_W-1:0] rx_data_o,
  output logic                       rx_valid_o,
  input  logic                       rx_ready_i,
  output logic                       rx_parity_err_o,
  output logic                       rx_frame_err_o,
  output logic                       rx_break_o,
  output logic                       rx_overrun_o,
  input  logic                       rx_ovr_clr_i,
  output logic                       rx_busy_o
);

  localparam int DLEN_W = TOTAL_CONF_W - DATA_LEN_LSB;
  localparam int MID_I  = mid_sample(OVERSAMPLE);
  localparam logic [SAMPLE_COUNT_W-1:0] MID      = SAMPLE_COUNT_W'(MID_I);
  localparam logic [SAMPLE_COUNT_W-1:0] LAST     = SAMPLE_COUNT_W'(last_sample(OVERSAMPLE));
  localparam logic [SAMPLE_COUNT_W-1:0] SCNT_ONE = SAMPLE_COUNT_W'(1);
  localparam logic [DATA_COUNTER_W-1:0] BCNT_ONE = DATA_COUNTER_W'(1);

  rx_state_e                    state_q;
  logic [SAMPLE_COUNT_W-1:0]    sample_cnt_q;
  logic [DATA_COUNTER_W-1:0]    bit_cnt_q;
  logic                         stop_idx_q;
  logic [TOTAL_CONF_W-1:0]      conf_q;
  logic [MAX_UART_DATA_W-1:0]   data_q;
  logic                         par_acc_q;
  logic                         par_err_q;
  logic                         frame_err_q;
  logic                         any_one_q;
  logic                         line_high_q;
  logic                         done_q;
  logic                         bit_val;
  logic [DLEN_W-1:0]            data_len;
  logic [DATA_COUNTER_W-1:0]    last_bit;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [SAMPLE_COUNT_W-1:0] MID_PRE = SAMPLE_COUNT_W'(MID_I - 1);
  localparam logic [SAMPLE_COUNT_W-1:0] DECIDE  = SAMPLE_COUNT_W'(MID_I + 1);
  logic [1:0] vote_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vote_q <= '0;
    end else if (baud_en_i) begin
      if (sample_cnt_q == MID_PRE) vote_q[0] <= uart_rx_i;
      if (sample_cnt_q == MID)     vote_q[1] <= uart_rx_i;
    end
  end

  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & uart_rx_i) | (vote_q[1] & uart_rx_i);
`else
  localparam logic [SAMPLE_COUNT_W-1:0] DECIDE = MID;
  assign bit_val = uart_rx_i;
`endif

  assign data_len = conf_q[TOTAL_CONF_W-1:DATA_LEN_LSB];

  always_comb begin
    int n;
    n = MIN_UART_DATA_W + int'(data_len);
    if (n > MAX_UART_DATA_W) n = MAX_UART_DATA_W;
    last_bit = DATA_COUNTER_W'(n - 1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_OFF;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      stop_idx_q   <= 1'b0;
      conf_q       <= '0;
      data_q       <= '0;
      par_acc_q    <= 1'b0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      any_one_q    <= 1'b0;
      line_high_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (baud_en_i) begin
        if (!rx_en_i) begin
          state_q      <= ST_OFF;
          sample_cnt_q <= '0;
          bit_cnt_q    <= '0;
          stop_idx_q   <= 1'b0;
          line_high_q  <= 1'b0;
        end else begin
          sample_cnt_q <= sample_cnt_q + SCNT_ONE;
          unique case (state_q)
            ST_OFF: begin
              state_q      <= ST_IDLE;
              sample_cnt_q <= '0;
            end
            ST_IDLE: begin
              sample_cnt_q <= '0;
              if (uart_rx_i) begin
                line_high_q <= 1'b1;
              end else if (line_high_q) begin
                // The edge-detect tick is sample 0 of the start bit.
                state_q      <= ST_START;
                sample_cnt_q <= SCNT_ONE;
                conf_q       <= rx_conf_i;
                data_q       <= '0;
                bit_cnt_q    <= '0;
                stop_idx_q   <= 1'b0;
                par_acc_q    <= 1'b0;
                par_err_q    <= 1'b0;
                frame_err_q  <= 1'b0;
                any_one_q    <= 1'b0;
              end
            end
            ST_START: begin
              if (sample_cnt_q == DECIDE && bit_val) begin
                state_q      <= ST_IDLE;
                sample_cnt_q <= '0;
              end else if (sample_cnt_q == LAST) begin
                state_q      <= ST_DATA;
                sample_cnt_q <= '0;
              end
            end
            ST_DATA: begin
              if (sample_cnt_q == DECIDE) begin
                data_q[bit_cnt_q] <= bit_val;
                par_acc_q         <= par_acc_q ^ bit_val;
                any_one_q         <= any_one_q | bit_val;
              end
              if (sample_cnt_q == LAST) begin
                sample_cnt_q <= '0;
                if (bit_cnt_q == last_bit) begin
                  bit_cnt_q <= '0;
                  state_q   <= conf_q[PARITY_EN_B] ? ST_PARITY : ST_STOP;
                end else begin
                  bit_cnt_q <= bit_cnt_q + BCNT_ONE;
                end
              end
            end
            ST_PARITY: begin
              if (sample_cnt_q == DECIDE) begin
                par_err_q <= bit_val != (par_acc_q ^ conf_q[PARITY_ODD_B]);
                any_one_q <= any_one_q | bit_val;
              end
              if (sample_cnt_q == LAST) begin
                sample_cnt_q <= '0;
                state_q      <= ST_STOP;
              end
            end
            ST_STOP: begin
              if (sample_cnt_q == DECIDE) begin
                frame_err_q <= frame_err_q | ~bit_val;
                any_one_q   <= any_one_q | bit_val;
                if (stop_idx_q == conf_q[STOP2_B]) begin
                  // Completing mid-bit lets a back-to-back start edge be caught on time;
                  // after a break the line must go high again before re-arming.
                  done_q       <= 1'b1;
                  state_q      <= ST_IDLE;
                  sample_cnt_q <= '0;
                  line_high_q  <= any_one_q | bit_val;
                end
              end else if (sample_cnt_q == LAST) begin
                stop_idx_q   <= 1'b1;
                sample_cnt_q <= '0;
              end
            end
            default: begin
              state_q      <= ST_OFF;
              sample_cnt_q <= '0;
            end
          endcase
        end
      end
    end
  end

  assign rx_busy_o = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_rx_holding_reg #(
    .DATA_W(MAX_UART_DATA_W)
  ) u_holding (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (done_q),
    .data_i       (data_q),
    .parity_err_i (par_err_q),
    .frame_err_i  (frame_err_q),
    .break_i      (~any_one_q),
    .ready_i      (rx_ready_i),
    .ovr_clr_i    (rx_ovr_clr_i),
    .data_o       (rx_data_o),
    .valid_o      (rx_valid_o),
    .parity_err_o (rx_parity_err_o),
    .frame_err_o  (rx_frame_err_o),
    .break_o      (rx_break_o),
    .overrun_o    (rx_overrun_o)
  );

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed bench for uart_rx_core (baud tick every clk, 16x oversampling)
module tb_uart_rx_core;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       baud_en_i = 1'b1;
  logic       rx_en_i = 1'b0;
  logic       uart_rx_i = 1'b1;
  logic [4:0] rx_conf_i = 5'h18;
  logic [8:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic       rx_parity_err_o;
  logic       rx_frame_err_o;
  logic       rx_break_o;
  logic       rx_overrun_o;
  logic       rx_ovr_clr_i = 1'b0;
  logic       rx_busy_o;

  localparam logic [4:0] CONF_8N1 = 5'h18;
  localparam logic [4:0] CONF_7O2 = 5'h17;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_core dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .baud_en_i       (baud_en_i),
    .rx_en_i         (rx_en_i),
    .uart_rx_i       (uart_rx_i),
    .rx_conf_i       (rx_conf_i),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i),
    .rx_parity_err_o (rx_parity_err_o),
    .rx_frame_err_o  (rx_frame_err_o),
    .rx_break_o      (rx_break_o),
    .rx_overrun_o    (rx_overrun_o),
    .rx_ovr_clr_i    (rx_ovr_clr_i),
    .rx_busy_o       (rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic consume();
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
  endtask

  // Positions: 0 = start, 1..nbits = data LSB first, then parity, then stop bits.
  task automatic send_frame(input logic [8:0] d, input int nbits, input bit pen, input bit pbit,
                            input int nstop, input int gpos, input int gsamp);
    logic [12:0] bits;
    int total;
    bits = '0;
    for (int i = 0; i < nbits; i++) bits[1+i] = d[i];
    total = 1 + nbits;
    if (pen) begin
      bits[total] = pbit;
      total++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[total] = 1'b1;
      total++;
    end
    for (int p = 0; p < total; p++) begin
      for (int s = 0; s < 16; s++) begin
        uart_rx_i = (p == gpos && s == gsamp) ? ~bits[p] : bits[p];
        tick(1);
      end
    end
    uart_rx_i = 1'b1;
  endtask

  initial begin
    tick(2);
    check("rst_valid", rx_valid_o, 0);
    check("rst_data", rx_data_o, 0);
    check("rst_flags", {rx_parity_err_o, rx_frame_err_o, rx_break_o, rx_overrun_o}, 0);
    check("rst_busy", rx_busy_o, 0);

    rst_i = 1'b0;
    rx_en_i = 1'b1;
    tick(4);
    check("idle_busy", rx_busy_o, 0);

    // 8N1, 0xA5
    rx_conf_i = CONF_8N1;
    send_frame(9'h0A5, 8, 0, 0, 1, -1, 0);
    check("a5_valid", rx_valid_o, 1);
    check("a5_data", rx_data_o, 9'h0A5);
    check("a5_flags", {rx_parity_err_o, rx_frame_err_o, rx_break_o, rx_overrun_o}, 0);
    consume();
    check("a5_consumed", rx_valid_o, 0);
    check("a5_data_hold", rx_data_o, 9'h0A5);

    // 7O2: 0x35 has even popcount, so odd parity expects bit=1
    rx_conf_i = CONF_7O2;
    send_frame(9'h035, 7, 1, 0, 2, -1, 0);
    check("7o2_bad_data", rx_data_o, 9'h035);
    check("7o2_bad_perr", rx_parity_err_o, 1);
    check("7o2_bad_ferr", rx_frame_err_o, 0);
    consume();
    send_frame(9'h035, 7, 1, 1, 2, -1, 0);
    check("7o2_good_valid", rx_valid_o, 1);
    check("7o2_good_perr", rx_parity_err_o, 0);
    check("7o2_good_data", rx_data_o, 9'h035);
    consume();

    // overrun
    rx_conf_i = CONF_8N1;
    send_frame(9'h011, 8, 0, 0, 1, -1, 0);
    send_frame(9'h022, 8, 0, 0, 1, -1, 0);
    check("ovr_data", rx_data_o, 9'h011);
    check("ovr_valid", rx_valid_o, 1);
    check("ovr_flag", rx_overrun_o, 1);
    rx_ovr_clr_i = 1'b1;
    tick(1);
    rx_ovr_clr_i = 1'b0;
    check("ovr_clr", rx_overrun_o, 0);
    consume();
    check("ovr_consumed", rx_valid_o, 0);

    // break: 12 bit times low
    uart_rx_i = 1'b0;
    tick(192);
    check("brk_valid", rx_valid_o, 1);
    check("brk_data", rx_data_o, 0);
    check("brk_flag", rx_break_o, 1);
    check("brk_ferr", rx_frame_err_o, 1);
    check("brk_busy", rx_busy_o, 0);
    uart_rx_i = 1'b1;
    tick(20);
    check("brk_no_second", rx_overrun_o, 0);
    consume();
    send_frame(9'h05A, 8, 0, 0, 1, -1, 0);
    check("post_brk_data", rx_data_o, 9'h05A);
    check("post_brk_flags", {rx_break_o, rx_frame_err_o}, 0);
    consume();

    // 4-tick glitch on idle line
    uart_rx_i = 1'b0;
    tick(4);
    uart_rx_i = 1'b1;
    tick(20);
    check("glitch_busy", rx_busy_o, 0);
    check("glitch_valid", rx_valid_o, 0);

    // disable mid-DATA
    uart_rx_i = 1'b0;
    tick(40);
    check("en_busy_before", rx_busy_o, 1);
    rx_en_i = 1'b0;
    tick(1);
    check("en_off_busy", rx_busy_o, 0);
    uart_rx_i = 1'b1;
    tick(2);
    rx_en_i = 1'b1;
    tick(200);
    check("en_no_valid", rx_valid_o, 0);

    // async reset mid-frame with a held frame present
    send_frame(9'h077, 8, 0, 0, 1, -1, 0);
    check("pre_rst_valid", rx_valid_o, 1);
    uart_rx_i = 1'b0;
    tick(30);
    #3 rst_i = 1'b1;
    #1;
    check("arst_valid", rx_valid_o, 0);
    check("arst_data", rx_data_o, 0);
    check("arst_busy", rx_busy_o, 0);
    uart_rx_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
    tick(4);
    send_frame(9'h03C, 8, 0, 0, 1, -1, 0);
    check("after_rst_data", rx_data_o, 9'h03C);
    check("after_rst_valid", rx_valid_o, 1);
    consume();

    // off-centre glitch inside data bit 2
    send_frame(9'h03C, 8, 0, 0, 1, 3, 3);
    check("offmid_glitch_data", rx_data_o, 9'h03C);
    consume();

`ifdef UART_RX_MAJORITY_VOTE_EN
    send_frame(9'h03C, 8, 0, 0, 1, 3, 7);
    check("vote_mid_glitch_data", rx_data_o, 9'h03C);
    consume();
    send_frame(9'h03C, 8, 0, 0, 1, 0, 7);
    check("vote_start_glitch_valid", rx_valid_o, 1);
    check("vote_start_glitch_data", rx_data_o, 9'h03C);
    consume();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
